// File: rtl/divider_scheduler.sv
// Round-robin front end sharing one iterative 8-bit divider among N_REQ requesters.
// Gnt one cycle after arbitration; response held on RspValid until the owner's RspAck.
module divider_scheduler #(
  parameter int N_REQ = 4
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic [N_REQ-1:0]   Req,
  input  logic [N_REQ*8-1:0] ReqX,
  input  logic [N_REQ*8-1:0] ReqY,
  output logic [N_REQ-1:0]   Gnt,
  output logic [N_REQ-1:0]   RspValid,
  output logic [7:0]         RspQuo,
  output logic [7:0]         RspRem,
  output logic               RspErr,
  input  logic [N_REQ-1:0]   RspAck,
  input  logic               Scen,
  output logic [7:0]         div_Xin,
  output logic [7:0]         div_Yin,
  output logic               div_Start,
  output logic               div_Ack,
  output logic               div_SCEN,
  input  logic               div_Done,
  input  logic [7:0]         div_Quotient,
  input  logic [7:0]         div_Remainder
);
  localparam int IW = $clog2(N_REQ);

  typedef enum logic [4:0] {
    S_IDLE   = 5'b00001,
    S_LAUNCH = 5'b00010,
    S_WAIT   = 5'b00100,
    S_ACK    = 5'b01000,
    S_RESP   = 5'b10000
  } state_t;

  state_t           r_state, w_state;
  logic [IW-1:0]    r_last, w_last, r_id, w_id, w_win;
  logic             w_any;
  logic [7:0]       r_x, w_x, r_y, w_y, w_req_x, w_req_y;
  logic [7:0]       r_quo, w_quo, r_rem, w_rem;
  logic             r_err, w_err, r_start, w_start, r_ack, w_ack;
  logic [N_REQ-1:0] r_gnt, w_gnt, r_vld, w_vld, w_win_oh, w_id_oh;

  // Smallest rotation distance from the last winner wins; descending k lets it overwrite.
  always_comb begin
    w_any = 1'b0;
    w_win = r_last;
    for (int k = N_REQ; k >= 1; k--) begin
      for (int i = 0; i < N_REQ; i++) begin
        if (Req[i] && (i == (int'(r_last) + k) % N_REQ)) begin
          w_any = 1'b1;
          w_win = IW'(i);
        end
      end
    end
  end

  always_comb begin
    w_req_x = 8'h00;
    w_req_y = 8'h00;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_win == IW'(i)) begin
        w_req_x = ReqX[8*i +: 8];
        w_req_y = ReqY[8*i +: 8];
      end
    end
  end

  assign w_win_oh = N_REQ'(1) << w_win;
  assign w_id_oh  = N_REQ'(1) << r_id;

  always_comb begin
    w_state = r_state;
    w_last  = r_last;
    w_id    = r_id;
    w_x     = r_x;
    w_y     = r_y;
    w_quo   = r_quo;
    w_rem   = r_rem;
    w_err   = r_err;
    w_gnt   = '0;
    w_vld   = r_vld;
    w_start = 1'b0;
    w_ack   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_any) begin
          w_last = w_win;
          w_id   = w_win;
          w_x    = w_req_x;
          w_y    = w_req_y;
          w_gnt  = w_win_oh;
          // A zero divisor would never let the divider finish, so answer it here.
          if (w_req_y == 8'h00) begin
            w_state = S_RESP;
            w_quo   = 8'hFF;
            w_rem   = w_req_x;
            w_err   = 1'b1;
            w_vld   = w_win_oh;
          end else begin
            w_state = S_LAUNCH;
            w_start = 1'b1;
          end
        end
      end
      S_LAUNCH: w_state = S_WAIT;
      S_WAIT: begin
        if (div_Done) begin
          w_state = S_ACK;
          w_quo   = div_Quotient;
          w_rem   = div_Remainder;
          w_err   = 1'b0;
          w_ack   = 1'b1;
        end
      end
      S_ACK: begin
        w_state = S_RESP;
        w_vld   = w_id_oh;
      end
      S_RESP: begin
        if (|(RspAck & r_vld)) begin
          w_state = S_IDLE;
          w_vld   = '0;
        end
      end
      default: begin
        w_state = S_IDLE;
        w_vld   = '0;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state <= S_IDLE;
      r_last  <= IW'(N_REQ - 1);
      r_id    <= '0;
      r_x     <= 8'h00;
      r_y     <= 8'h00;
      r_quo   <= 8'h00;
      r_rem   <= 8'h00;
      r_err   <= 1'b0;
      r_gnt   <= '0;
      r_vld   <= '0;
      r_start <= 1'b0;
      r_ack   <= 1'b0;
    end else begin
      r_state <= w_state;
      r_last  <= w_last;
      r_id    <= w_id;
      r_x     <= w_x;
      r_y     <= w_y;
      r_quo   <= w_quo;
      r_rem   <= w_rem;
      r_err   <= w_err;
      r_gnt   <= w_gnt;
      r_vld   <= w_vld;
      r_start <= w_start;
      r_ack   <= w_ack;
    end
  end

  assign Gnt       = r_gnt;
  assign RspValid  = r_vld;
  assign RspQuo    = r_quo;
  assign RspRem    = r_rem;
  assign RspErr    = r_err;
  assign div_Xin   = r_x;
  assign div_Yin   = r_y;
  assign div_Start = r_start;
  assign div_Ack   = r_ack;
  assign div_SCEN  = Scen;

endmodule

// File: tb/tb_divider_scheduler.sv
// Bench for divider_scheduler: directed requester sequences, a behavioural divider,
// and a transaction-level reference model compared against the outputs every cycle.
module tb_divider_scheduler;
  localparam int N       = 4;
  localparam int DIV_LAT = 3;

  logic           Clk = 1'b0;
  logic           Reset_n;
  logic [N-1:0]   Req, RspAck, Gnt, RspValid;
  logic [N*8-1:0] ReqX, ReqY;
  logic [7:0]     RspQuo, RspRem, div_Xin, div_Yin, div_Quotient, div_Remainder;
  logic           RspErr, Scen, div_Start, div_Ack, div_SCEN, div_Done;
  logic [7:0]     rx [N];
  logic [7:0]     ry [N];

  int n_cmp = 0;
  int n_bad = 0;

  divider_scheduler #(.N_REQ(N)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .Req(Req), .ReqX(ReqX), .ReqY(ReqY),
    .Gnt(Gnt), .RspValid(RspValid), .RspQuo(RspQuo), .RspRem(RspRem), .RspErr(RspErr),
    .RspAck(RspAck), .Scen(Scen), .div_Xin(div_Xin), .div_Yin(div_Yin),
    .div_Start(div_Start), .div_Ack(div_Ack), .div_SCEN(div_SCEN), .div_Done(div_Done),
    .div_Quotient(div_Quotient), .div_Remainder(div_Remainder)
  );

  always #5 Clk = ~Clk;

  always_comb begin
    ReqX = '0;
    ReqY = '0;
    for (int i = 0; i < N; i++) begin
      ReqX[8*i +: 8] = rx[i];
      ReqY[8*i +: 8] = ry[i];
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Behavioural iterative divider: DIV_LAT+1 enabled cycles after Start, Done held until Ack.
  initial begin
    int d_x, d_y, d_cnt;
    bit d_busy;
    d_busy = 0; d_x = 0; d_y = 0; d_cnt = 0;
    div_Done = 1'b0; div_Quotient = 8'h00; div_Remainder = 8'h00;
    forever begin
      @(posedge Clk); #1;
      if (!Reset_n) begin
        d_busy = 0; div_Done = 1'b0;
      end else if (div_Ack) begin
        d_busy = 0; div_Done = 1'b0;
      end else if (div_Start) begin
        d_x = int'(div_Xin); d_y = int'(div_Yin); d_cnt = DIV_LAT; d_busy = 1;
      end else if (d_busy && !div_Done && Scen) begin
        if (d_cnt == 0) begin
          div_Done      = 1'b1;
          div_Quotient  = (d_y == 0) ? 8'h00 : 8'(d_x / d_y);
          div_Remainder = (d_y == 0) ? 8'h00 : 8'(d_x % d_y);
        end else begin
          d_cnt--;
        end
      end
    end
  end

  // Reference model: phase 0 idle, 1 granted and computing, 2 response pending.
  initial begin
    int m_phase, m_last, m_id, m_x, m_y, m_q, m_r, m_e, m_starts, m_exp_gnt, m_ack_prev;
    int ph0, win, ev;
    m_phase = 0; m_last = N - 1; m_id = 0; m_x = 0; m_y = 0; m_q = 0; m_r = 0; m_e = 0;
    m_starts = 0; m_exp_gnt = 0; m_ack_prev = 0;
    forever begin
      @(negedge Clk); #2;
      if (!Reset_n) begin
        chk("rst_gnt",   int'(Gnt), 0);
        chk("rst_vld",   int'(RspValid), 0);
        chk("rst_start", int'(div_Start), 0);
        chk("rst_ack",   int'(div_Ack), 0);
        chk("rst_err",   int'(RspErr), 0);
        chk("rst_quo",   int'(RspQuo), 0);
        chk("rst_rem",   int'(RspRem), 0);
        chk("rst_xin",   int'(div_Xin), 0);
        chk("rst_yin",   int'(div_Yin), 0);
        m_phase = 0; m_last = N - 1; m_exp_gnt = 0; m_ack_prev = 0;
      end else begin
        ph0 = m_phase;
        chk("gnt", int'(Gnt), m_exp_gnt);
        chk("start_ack_excl", int'(div_Start & div_Ack), 0);
        chk("scen_pass", int'(div_SCEN), int'(Scen));
        if (ph0 != 1) begin
          chk("start_idle", int'(div_Start), 0);
          chk("ack_idle", int'(div_Ack), 0);
        end else begin
          if (div_Start) m_starts++;
          chk("xin_hold", int'(div_Xin), m_x);
          chk("yin_hold", int'(div_Yin), m_y);
          if (m_e != 0 || m_ack_prev != 0) begin
            chk("start_count", m_starts, (m_e != 0) ? 0 : 1);
            m_phase = 2;
          end
        end
        ev = (m_phase == 2) ? (1 << m_id) : 0;
        chk("vld", int'(RspValid), ev);
        if (m_phase == 2) begin
          chk("quo", int'(RspQuo), m_q);
          chk("rem", int'(RspRem), m_r);
          chk("err", int'(RspErr), m_e);
          if (RspAck[m_id]) m_phase = 0;
        end
        m_ack_prev = int'(div_Ack);
        m_exp_gnt = 0;
        if (ph0 == 0) begin
          win = -1;
          for (int k = 1; k <= N; k++) begin
            if (win < 0 && Req[(m_last + k) % N]) win = (m_last + k) % N;
          end
          if (win >= 0) begin
            m_last = win; m_id = win;
            m_x = int'(rx[win]); m_y = int'(ry[win]);
            m_e = (m_y == 0) ? 1 : 0;
            m_q = (m_e != 0) ? 255 : m_x / m_y;
            m_r = (m_e != 0) ? m_x : m_x % m_y;
            m_exp_gnt = 1 << win;
            m_starts = 0;
            m_phase = 1;
          end
        end
      end
    end
  end

  // One requester transaction with hand-computed expectations.
  task automatic serve(input int exp_id, input int eq, input int er, input int ee,
                       input int hold, input int stall);
    int t, g;
    t = 0;
    while (Gnt == '0 && t < 100) begin @(negedge Clk); t++; end
    chk("gnt_wait_ok", (t < 100) ? 1 : 0, 1);
    chk("gnt_id", int'(Gnt), 1 << exp_id);
    g = exp_id;
    for (int i = 0; i < N; i++) if (Gnt[i]) g = i;
    Req[g] = 1'b0;
    if (stall > 0) begin
      Scen = 1'b0;
      repeat (stall) @(negedge Clk);
      chk("stall_no_vld", int'(RspValid), 0);
      chk("stall_no_done", int'(div_Done), 0);
      Scen = 1'b1;
    end
    t = 0;
    while (RspValid == '0 && t < 200) begin @(negedge Clk); t++; end
    chk("vld_wait_ok", (t < 200) ? 1 : 0, 1);
    chk("rsp_vld", int'(RspValid), 1 << exp_id);
    chk("rsp_quo", int'(RspQuo), eq);
    chk("rsp_rem", int'(RspRem), er);
    chk("rsp_err", int'(RspErr), ee);
    repeat (hold) begin
      @(negedge Clk);
      chk("hold_vld", int'(RspValid), 1 << exp_id);
      chk("hold_quo", int'(RspQuo), eq);
      chk("hold_rem", int'(RspRem), er);
    end
    RspAck[g] = 1'b1;
    @(negedge Clk);
    RspAck = '0;
  endtask

  initial begin
    int t;
    Reset_n = 1'b0; Req = '0; RspAck = '0; Scen = 1'b1;
    for (int i = 0; i < N; i++) begin rx[i] = 8'd0; ry[i] = 8'd0; end
    repeat (3) @(negedge Clk);
    Reset_n = 1'b1;
    repeat (2) @(negedge Clk);

    // Fairness from reset: requester 0 first, then rotation.
    rx[0] = 8'd200; ry[0] = 8'd3;
    rx[1] = 8'd200; ry[1] = 8'd5;
    rx[2] = 8'd200; ry[2] = 8'd9;
    rx[3] = 8'd200; ry[3] = 8'd201;
    Req = 4'b1111;
    serve(0, 66, 2, 0, 0, 0);
    serve(1, 40, 0, 0, 0, 0);
    serve(2, 22, 2, 0, 0, 0);
    serve(3, 0, 200, 0, 0, 0);

    // Pointer wrap after serving requester 3.
    rx[0] = 8'd10;  ry[0] = 8'd3;
    rx[3] = 8'd255; ry[3] = 8'd16;
    Req = 4'b1001;
    serve(0, 3, 1, 0, 0, 0);
    serve(3, 15, 15, 0, 0, 0);

    // Single request with ten cycles of response back-pressure.
    rx[0] = 8'd100; ry[0] = 8'd7;
    Req[0] = 1'b1;
    serve(0, 14, 2, 0, 10, 0);

    // Divide-by-zero short-circuit.
    rx[2] = 8'd77; ry[2] = 8'd0;
    Req[2] = 1'b1;
    serve(2, 255, 77, 1, 2, 0);

    // Single-step stall while the divider is computing; zero dividend.
    rx[1] = 8'd50; ry[1] = 8'd6;
    Req[1] = 1'b1;
    serve(1, 8, 2, 0, 0, 20);
    rx[1] = 8'd0; ry[1] = 8'd5;
    Req[1] = 1'b1;
    serve(1, 0, 0, 0, 0, 0);

    // Reset while waiting for Done, then a fresh request.
    rx[3] = 8'd90; ry[3] = 8'd9;
    Req[3] = 1'b1;
    t = 0;
    while (Gnt == '0 && t < 100) begin @(negedge Clk); t++; end
    chk("rst_gnt_wait_ok", (t < 100) ? 1 : 0, 1);
    Req = '0;
    repeat (2) @(negedge Clk);
    Reset_n = 1'b0;
    #1;
    chk("midrst_vld",   int'(RspValid), 0);
    chk("midrst_start", int'(div_Start), 0);
    chk("midrst_xin",   int'(div_Xin), 0);
    chk("midrst_yin",   int'(div_Yin), 0);
    repeat (3) @(negedge Clk);
    Reset_n = 1'b1;
    @(negedge Clk);
    rx[1] = 8'd9; ry[1] = 8'd4;
    Req[1] = 1'b1;
    serve(1, 2, 1, 0, 0, 0);

    repeat (4) @(negedge Clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
